// File: rtl/burst_tx_pkg.sv
// Shared types and constants for the burst transmitter.
// Holds the FSM state encoding, default sizing and the running max/min seeds.
package burst_tx_pkg;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_SEND,
    ST_WAIT,
    ST_REPORT
  } state_t;

  localparam int BURST_LEN_DEF    = 15;
  localparam int RESP_TIMEOUT_DEF = 8;

  localparam logic [7:0] MAX_INIT = 8'd0;
  localparam logic [7:0] MIN_INIT = 8'd255;

endpackage

// File: rtl/burst_tx_buf.sv
// 16x8 sample store: one write port, one registered read port.
// Read data appears the cycle after i_rd_en and is forced to 0 when no read is issued.
module burst_tx_buf (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_wr_en,
  input  logic [3:0] i_wr_addr,
  input  logic [7:0] i_wr_dat,
  input  logic       i_rd_en,
  input  logic [3:0] i_rd_addr,
  output logic [7:0] o_rd_dat
);

  logic [7:0] r_mem [16];
  logic [7:0] r_rd_dat;

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_dat;
  end

  // Only the read register is reset; storage is always written before it is read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rd_dat <= 8'd0;
    else        r_rd_dat <= i_rd_en ? r_mem[i_rd_addr] : 8'd0;
  end

  assign o_rd_dat = r_rd_dat;

endmodule

// File: rtl/burst_tx.sv
// Collects BURST_LEN host samples, replays them as a contiguous burst, then checks the downstream max/min result.
// Beats start 2 cycles after the last accepted sample; wr_ready is held low outside FILL.
module burst_tx
  import burst_tx_pkg::*;
#(
  parameter int BURST_LEN    = BURST_LEN_DEF,
  parameter int RESP_TIMEOUT = RESP_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_wr_valid,
  input  logic [7:0] i_wr_data,
  output logic       o_wr_ready,
  output logic       o_tx_valid,
  output logic [7:0] o_tx_data,
  input  logic       i_rx_valid,
  input  logic [7:0] i_rx_max,
  input  logic [7:0] i_rx_min,
  output logic       o_res_valid,
  output logic [7:0] o_res_max,
  output logic [7:0] o_res_min,
  output logic [1:0] o_res_err,
  output logic       o_busy
);

  localparam int              TW    = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
  localparam logic [4:0]      LEN   = 5'(BURST_LEN);
  localparam logic [TW-1:0]   TLAST = TW'(RESP_TIMEOUT - 1);

  state_t        r_state;
  state_t        w_next;
  logic [4:0]    r_cnt;
  logic [4:0]    r_ptr;
  logic [TW-1:0] r_timer;
  logic [7:0]    r_exp_max;
  logic [7:0]    r_exp_min;
  logic          r_tx_valid;
  logic [7:0]    r_res_max;
  logic [7:0]    r_res_min;
  logic [1:0]    r_res_err;
  logic          w_wr_acc;
  logic          w_rd_en;
  logic          w_timeout;
  logic [7:0]    w_rd_dat;

  assign w_wr_acc  = i_wr_valid && o_wr_ready;
  assign w_rd_en   = (r_state == ST_SEND);
  assign w_timeout = (r_timer == TLAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_FILL;
    else        r_state <= w_next;
  end

  // The read port is one cycle ahead of tx, so WAIT begins on the cycle the last beat is on the wire.
  always_comb begin
    w_next      = r_state;
    o_wr_ready  = 1'b0;
    o_busy      = 1'b0;
    o_res_valid = 1'b0;
    case (r_state)
      ST_FILL: begin
        o_wr_ready = (r_cnt < LEN);
        if (i_wr_valid && (r_cnt == LEN - 5'd1)) w_next = ST_SEND;
      end
      ST_SEND: begin
        o_busy = 1'b1;
        if (r_ptr == LEN - 5'd1) w_next = ST_WAIT;
      end
      ST_WAIT: begin
        o_busy = 1'b1;
        if (i_rx_valid || w_timeout) w_next = ST_REPORT;
      end
      ST_REPORT: begin
        o_res_valid = 1'b1;
        w_next      = ST_FILL;
      end
      default: w_next = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= 5'd0;
      r_ptr      <= 5'd0;
      r_timer    <= '0;
      r_exp_max  <= MAX_INIT;
      r_exp_min  <= MIN_INIT;
      r_tx_valid <= 1'b0;
      r_res_max  <= MAX_INIT;
      r_res_min  <= MIN_INIT;
      r_res_err  <= 2'b00;
    end else begin
      r_tx_valid <= w_rd_en;
      case (r_state)
        ST_FILL: begin
          r_ptr <= 5'd0;
          if (w_wr_acc) begin
            r_cnt <= r_cnt + 5'd1;
            if (i_wr_data > r_exp_max) r_exp_max <= i_wr_data;
            if (i_wr_data < r_exp_min) r_exp_min <= i_wr_data;
          end
        end
        ST_SEND: begin
          r_ptr   <= r_ptr + 5'd1;
          r_timer <= '0;
        end
        ST_WAIT: begin
          r_timer <= r_timer + TW'(1);
          // A result arriving on the timeout cycle still counts as a real result.
          if (i_rx_valid) begin
            r_res_max <= i_rx_max;
            r_res_min <= i_rx_min;
            r_res_err <= {(i_rx_max != r_exp_max) || (i_rx_min != r_exp_min), 1'b0};
          end else if (w_timeout) begin
            r_res_max <= MAX_INIT;
            r_res_min <= MIN_INIT;
            r_res_err <= 2'b01;
          end
        end
        ST_REPORT: begin
          r_cnt     <= 5'd0;
          r_exp_max <= MAX_INIT;
          r_exp_min <= MIN_INIT;
        end
        default: ;
      endcase
    end
  end

  burst_tx_buf u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (r_cnt[3:0]),
    .i_wr_dat  (i_wr_data),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (r_ptr[3:0]),
    .o_rd_dat  (w_rd_dat)
  );

  assign o_tx_valid = r_tx_valid;
  assign o_tx_data  = w_rd_dat;
  assign o_res_max  = r_res_max;
  assign o_res_min  = r_res_min;
  assign o_res_err  = r_res_err;

endmodule

// File: tb/tb_burst_tx.sv
// Scoreboard bench for burst_tx: stimulus queues expected beats/results, a negedge monitor pops and compares.
module tb_burst_tx;

  localparam int BL = 15;
  localparam int RT = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = 8'd0;
  logic       wr_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_max = 8'd0;
  logic [7:0] rx_min = 8'd0;
  logic       res_valid;
  logic [7:0] res_max;
  logic [7:0] res_min;
  logic [1:0] res_err;
  logic       busy;

  always #5 clk = ~clk;

  burst_tx #(.BURST_LEN(BL), .RESP_TIMEOUT(RT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_wr_valid  (wr_valid),
    .i_wr_data   (wr_data),
    .o_wr_ready  (wr_ready),
    .o_tx_valid  (tx_valid),
    .o_tx_data   (tx_data),
    .i_rx_valid  (rx_valid),
    .i_rx_max    (rx_max),
    .i_rx_min    (rx_min),
    .o_res_valid (res_valid),
    .o_res_max   (res_max),
    .o_res_min   (res_min),
    .o_res_err   (res_err),
    .o_busy      (busy)
  );

  typedef struct {
    int mx;
    int mn;
    int err;
    int dly;   // cycles from last beat to res_valid
  } res_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int tx_cnt = 0;
  int res_cnt = 0;
  int run = 0;
  int last_beat = 0;
  logic [7:0] exp_tx[$];
  res_t       exp_res[$];
  res_t       m_e;
  logic [7:0] m_t;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      run = 0;
    end else begin
      if (tx_valid) begin
        run++;
        tx_cnt++;
        last_beat = cyc;
        chk("busy_during_beat", int'(busy), 1);
        if (exp_tx.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_tx: got %0d want none", tx_data);
        end else begin
          m_t = exp_tx.pop_front();
          chk("tx_data", int'(tx_data), int'(m_t));
        end
      end else begin
        if (run != 0) begin
          chk("burst_len", run, BL);
          run = 0;
        end
        chk("tx_data_idle", int'(tx_data), 0);
      end
      if (res_valid) begin
        res_cnt++;
        if (exp_res.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_res: got %0d/%0d want none", res_max, res_min);
        end else begin
          m_e = exp_res.pop_front();
          chk("res_max", int'(res_max), m_e.mx);
          chk("res_min", int'(res_min), m_e.mn);
          chk("res_err", int'(res_err), m_e.err);
          chk("res_delay", cyc - last_beat, m_e.dly);
        end
      end
      if (busy || res_valid) chk("wr_ready_low", int'(wr_ready), 0);
    end
  end

  task automatic write(input logic [7:0] s[$], input int gap_mod);
    logic acc;
    foreach (s[i]) begin
      exp_tx.push_back(s[i]);
      wr_valid = 1'b1;
      wr_data  = s[i];
      acc = 1'b0;
      for (int k = 0; k < 100 && !acc; k++) begin
        @(negedge clk);
        acc = wr_ready;
        @(posedge clk);
        #1;
      end
      if (!acc) begin
        total++; bad++;
        $display("FAIL write_accept: got no ready want ready for sample %0d", i);
      end
      if (gap_mod > 0 && (i % gap_mod) != 0) begin
        wr_valid = 1'b0;
        repeat (i % gap_mod) @(posedge clk);
        #1;
      end
    end
    wr_valid = 1'b0;
  endtask

  task automatic wait_beats(input int target);
    for (int k = 0; k < 400; k++) begin
      if (tx_cnt >= target) break;
      @(negedge clk);
      #1;
    end
    if (tx_cnt < target) begin
      total++; bad++;
      $display("FAIL wait_beats: got %0d want %0d", tx_cnt, target);
    end
  endtask

  task automatic wait_res(input int target);
    for (int k = 0; k < 400; k++) begin
      if (res_cnt >= target) break;
      @(negedge clk);
      #1;
    end
    if (res_cnt < target) begin
      total++; bad++;
      $display("FAIL wait_res: got %0d want %0d", res_cnt, target);
    end
  endtask

  // Drives rx during the d-th cycle after the last beat (called from that beat's negedge).
  task automatic respond(input int d, input logic [7:0] mx, input logic [7:0] mn);
    repeat (d) @(posedge clk);
    #1;
    rx_valid = 1'b1; rx_max = mx; rx_min = mn;
    @(posedge clk);
    #1;
    rx_valid = 1'b0; rx_max = 8'd0; rx_min = 8'd0;
  endtask

  task automatic pulse_rx(input logic [7:0] mx, input logic [7:0] mn);
    rx_valid = 1'b1; rx_max = mx; rx_min = mn;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s[$];
    int base;
    int rbase;

    #12;
    chk("rst_tx_valid",  int'(tx_valid),  0);
    chk("rst_tx_data",   int'(tx_data),   0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_res_max",   int'(res_max),   0);
    chk("rst_res_min",   int'(res_min),   255);
    chk("rst_res_err",   int'(res_err),   0);
    chk("rst_busy",      int'(busy),      0);
    chk("rst_wr_ready",  int'(wr_ready),  1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Burst 1..15, correct answer two cycles after last beat
    s = {};
    for (int i = 1; i <= 15; i++) s.push_back(8'(i));
    exp_res.push_back('{mx: 15, mn: 1, err: 0, dly: 3});
    base = tx_cnt; rbase = res_cnt;
    write(s, 0);
    wait_beats(base + 15);
    respond(2, 8'd15, 8'd1);
    wait_res(rbase + 1);

    // Gapped writes, no answer -> timeout
    s = {};
    for (int i = 0; i < 15; i++) s.push_back(8'(30 + 5 * i));
    exp_res.push_back('{mx: 0, mn: 255, err: 1, dly: RT});
    base = tx_cnt; rbase = res_cnt;
    write(s, 3);
    wait_beats(base + 15);
    wait_res(rbase + 1);

    // All 200, wrong min returned
    s = {};
    for (int i = 0; i < 15; i++) s.push_back(8'd200);
    exp_res.push_back('{mx: 200, mn: 199, err: 2, dly: 3});
    base = tx_cnt; rbase = res_cnt;
    write(s, 0);
    wait_beats(base + 15);
    respond(2, 8'd200, 8'd199);
    wait_res(rbase + 1);

    // Stray rx in FILL, then a correct answer exactly on the timeout cycle
    pulse_rx(8'd1, 8'd2);
    @(posedge clk); #1;
    pulse_rx(8'd9, 8'd9);
    s = {8'd40, 8'd3, 8'd77, 8'd250, 8'd12, 8'd9, 8'd180, 8'd66,
         8'd5, 8'd91, 8'd33, 8'd128, 8'd7, 8'd200, 8'd64};
    exp_res.push_back('{mx: 250, mn: 3, err: 0, dly: RT});
    base = tx_cnt; rbase = res_cnt;
    write(s, 0);
    wait_beats(base + 15);
    respond(RT - 1, 8'd250, 8'd3);
    wait_res(rbase + 1);

    // Reset on the 7th beat
    s = {};
    for (int i = 10; i <= 24; i++) s.push_back(8'(i));
    base = tx_cnt;
    write(s, 0);
    wait_beats(base + 7);
    rst_n = 1'b0;
    exp_tx.delete();
    #1;
    chk("mid_rst_tx_valid",  int'(tx_valid),  0);
    chk("mid_rst_tx_data",   int'(tx_data),   0);
    chk("mid_rst_res_valid", int'(res_valid), 0);
    chk("mid_rst_res_max",   int'(res_max),   0);
    chk("mid_rst_res_min",   int'(res_min),   255);
    chk("mid_rst_res_err",   int'(res_err),   0);
    chk("mid_rst_busy",      int'(busy),      0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    s = {};
    for (int i = 100; i <= 114; i++) s.push_back(8'(i));
    exp_res.push_back('{mx: 114, mn: 100, err: 0, dly: 3});
    base = tx_cnt; rbase = res_cnt;
    write(s, 0);
    wait_beats(base + 15);
    respond(2, 8'd114, 8'd100);
    wait_res(rbase + 1);

    // wr_valid held high across two bursts, both time out
    s = {};
    for (int i = 50; i < 80; i++) s.push_back(8'(i));
    exp_res.push_back('{mx: 0, mn: 255, err: 1, dly: RT});
    exp_res.push_back('{mx: 0, mn: 255, err: 1, dly: RT});
    base = tx_cnt; rbase = res_cnt;
    write(s, 0);
    wait_beats(base + 30);
    wait_res(rbase + 2);

    repeat (5) @(posedge clk);
    #1;
    chk("tx_queue_drained",  exp_tx.size(),  0);
    chk("res_queue_drained", exp_res.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/burst_tx.md
BURST_TX -- requirements
Module: burst_tx

Interface
REQ-001 Parameter BURST_LEN, default 15; number of 8-bit samples per burst.
REQ-002 Parameter RESP_TIMEOUT, default 8; cycles to wait for a result after the last beat.
REQ-003 clk  input  1  clock; all state updates on posedge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 wr_valid  input  1  host offers a sample.
REQ-006 wr_data  input  8  host sample, unsigned.
REQ-007 wr_ready  output  1  block accepts a sample this cycle.
REQ-008 tx_valid  output  1  burst beat valid toward the downstream max/min unit.
REQ-009 tx_data  output  8  burst beat data.
REQ-010 rx_valid  input  1  downstream result strobe.
REQ-011 rx_max, rx_min  input  8 each  downstream result values.
REQ-012 res_valid  output  1  one-cycle result pulse to host.
REQ-013 res_max, res_min  output  8 each  captured result.
REQ-014 res_err  output  2  bit0 timeout, bit1 mismatch against expected.
REQ-015 busy  output  1  high in SEND and WAIT.

Function
REQ-016 FSM states FILL, SEND, WAIT, REPORT; after reset in FILL.
REQ-017 FILL: wr_ready=1 while count<BURST_LEN; a sample is accepted when wr_valid&&wr_ready and stored at buffer[count]; count increments.
REQ-018 FILL: each accepted sample updates running exp_max (init 0) and exp_min (init 255) with unsigned compare.
REQ-019 FILL -> SEND on the cycle after the BURST_LENth sample is accepted; wr_ready=0 in every state other than FILL.
REQ-020 SEND: tx_valid=1 for exactly BURST_LEN consecutive cycles, tx_data=buffer[0..BURST_LEN-1] in write order; tx_valid/tx_data registered; tx_data=0 when tx_valid=0.
REQ-021 SEND -> WAIT on the cycle after the last beat; timer cleared to 0.
REQ-022 WAIT: timer increments each cycle; rx_valid captures rx_max/rx_min and moves to REPORT.
REQ-023 WAIT: timer reaching RESP_TIMEOUT without rx_valid moves to REPORT with res_err[0]=1, res_max=0, res_min=255.
REQ-024 rx_valid in the same cycle the timer reaches RESP_TIMEOUT is treated as a valid result (rx wins).
REQ-025 res_err[1]=1 when captured rx_max!=exp_max or rx_min!=exp_min; res_err[1]=0 on timeout.
REQ-026 REPORT: res_valid=1 for exactly one cycle; res_max/res_min/res_err hold until the next REPORT; then -> FILL with count, exp_max, exp_min cleared.
REQ-027 rx_valid outside WAIT is ignored.
REQ-028 tx_valid is low for at least one cycle between consecutive bursts (guaranteed by WAIT/REPORT/FILL).

Reset
REQ-029 rst_n low forces FILL, count=0, timer=0, exp_max=0, exp_min=255, tx_valid=0, tx_data=0, res_valid=0, res_max=0, res_min=255, res_err=0, busy=0.
REQ-030 Reset asserted mid-SEND drops tx_valid immediately (asynchronous); the partial burst is not resumed after release.
REQ-031 Buffer contents need not be reset; they are never read before being written.

Structure
REQ-032 Package burst_tx_pkg holds the state enum, default BURST_LEN/RESP_TIMEOUT, and constants MAX_INIT=0, MIN_INIT=255.
REQ-033 One sub-module burst_tx_buf: 16x8 register file, one write port, one registered read port.
REQ-034 Counter and pointer widths of 4 bits are sufficient for defaults; BURST_LEN>16 is unsupported.

Verification
REQ-035 Write 1..15, model responds rx_valid 2 cycles after last beat with max=15,min=1 -> tx beats 1..15 contiguous, res_valid pulse, res=15/1, res_err=0.
REQ-036 Write 15 samples with gaps in wr_valid, never respond -> res_valid RESP_TIMEOUT cycles after last beat with res_err=01, res_max=0, res_min=255.
REQ-037 Samples all 200, model returns max=200,min=199 -> res_err=10, res_max=200, res_min=199.
REQ-038 rx_valid exactly at timeout cycle with correct values -> res_err=00; rx_valid pulsed during FILL -> ignored.
REQ-039 Assert rst_n low at 7th beat of SEND -> tx_valid=0 immediately, all outputs at reset values, next 15 writes produce a fresh full burst.
REQ-040 wr_valid held high throughout two bursts -> wr_ready low in SEND/WAIT/REPORT, exactly 15 samples per burst accepted, no sample lost or duplicated.
